// File: rtl/mult_iter.sv
// mult_iter: iterative shift-add multiplier producing a 2*WIDTH-bit product.
// Define MULT_SIGNED_EN to add the is_signed port and two's-complement mode.
module mult_iter #(
    parameter int WIDTH = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
`ifdef MULT_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               ovf_q, ovf_d;
`ifdef MULT_SIGNED_EN
    logic               neg_q, neg_d;
    logic               smode_q, smode_d;
    logic [WIDTH:0]     top;
`endif

    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   step;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] res;
    logic               res_ovf;

    // State register and datapath flops; reset discards any in-flight work.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
            smode_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
            smode_q  <= smode_d;
`endif
        end
    end

    // Next-state, shift-add iteration, result formatting and handshake.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;

        in_ready  = !reset && ((state_q == IDLE) ||
                               (state_q == DONE && out_ready));
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;

        a_mag = in1;
        b_mag = in2;
`ifdef MULT_SIGNED_EN
        neg_d   = neg_q;
        smode_d = smode_q;
        if (is_signed) begin
            a_mag = in1[WIDTH-1] ? -in1 : in1;
            b_mag = in2[WIDTH-1] ? -in2 : in2;
        end
`endif

        // One iteration: conditional add into the upper half, then shift.
        sum     = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        step    = mplier_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
        shifted = step >> 1;

        res     = shifted[2*WIDTH-1:0];
        res_ovf = |res[2*WIDTH-1:WIDTH];
`ifdef MULT_SIGNED_EN
        if (neg_q) begin
            res = -shifted[2*WIDTH-1:0];
        end
        top = res[2*WIDTH-1:WIDTH-1];
        if (smode_q) begin
            res_ovf = !((top == '0) || (&top));
        end
`endif

        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                acc_d    = shifted;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d   = res;
                    ovf_d   = res_ovf;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the DONE release so back-to-back has no bubble.
        if (accept) begin
            mcand_d  = a_mag;
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = '0;
`ifdef MULT_SIGNED_EN
            neg_d    = is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            smode_d  = is_signed;
`endif
            if (in1 == '0 || in2 == '0) begin
                out_d   = '0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign out = out_q;
    assign ovf = ovf_q;

endmodule

// File: doc/mult_iter.md
# mult_iter

Parametrised iterative shift-add multiplier, the sequential successor to the team's combinational 5x5 Wallace-tree multiplier. Takes two WIDTH-bit operands over a valid/ready handshake, computes the full 2*WIDTH-bit product in WIDTH cycles (1 cycle for a zero operand), flags results that do not fit in WIDTH bits, and holds the result until the consumer accepts it. Sits between the ALU issue logic and the writeback stage, where a multi-cycle multiply is acceptable.

## Interface
- WIDTH, 5: operand width in bits; legal range 2..32.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- in1  in  WIDTH  multiplicand.
- in2  in  WIDTH  multiplier.
- is_signed  in  1  two's-complement mode; present only with MULT_SIGNED_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  2*WIDTH  full product.
- ovf  out  1  product not representable in WIDTH bits.

## Operation
- States: IDLE, RUN, DONE. Reset value is IDLE, with out=0, ovf=0, out_valid=0, and in_ready=0 while reset is high.
- in_ready = (state==IDLE) || (state==DONE && out_ready); it is combinational from state and out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. At accept, latch in1/in2 (magnitudes in signed mode, plus result sign = sign(in1) XOR sign(in2)) and clear the accumulator and count.
  - If either operand is zero, go to DONE with out=0, ovf=0.
  - Otherwise, go to RUN with count=0.
- RUN, one iteration per cycle:
  - If multiplier LSB=1, add the multiplicand into the upper half of a (2*WIDTH+1)-bit accumulator.
  - Shift the accumulator right by 1 and count++.
  - When count reaches WIDTH-1 (the WIDTH-th iteration), load out (negated if the result sign is set), compute ovf, and go to DONE.
- DONE: out_valid=1. out and ovf are held stable until out_ready.
  - out_ready && in_valid: accept new operands in the same cycle (back-to-back; no bubble).
  - out_ready && !in_valid: go to IDLE and drop out_valid.
- out is not cleared on leaving DONE. It keeps its last value until the next result loads.
- ovf rules:
  - Unsigned: ovf = |out[2W-1:W].
  - Signed: ovf = 1 unless out[2W-1:W-1] is all 0s or all 1s.
- in_valid, in1, in2 and is_signed are ignored outside accept cycles. Operand changes during RUN have no effect.
- Reset high in any state forces IDLE next edge and discards in-flight work, with out and ovf cleared. No out_valid is produced for the aborted operation.

## Timing
- Latency, from accept edge to the edge after which out_valid=1:
  - WIDTH cycles for nonzero operands.
  - 1 cycle if either operand is zero.
- Throughput is one result per WIDTH cycles when the consumer is always ready.
- out_valid stays high for at least 1 cycle and for as long as out_ready=0.
- Reset takes effect on the first rising edge where reset=1. in_ready rises in the first cycle after reset deasserts.

## Configuration
- MULT_SIGNED_EN defined:
  - Adds the is_signed port.
  - is_signed=1 treats operands and product as two's complement, using magnitude multiply plus a final negate and the signed ovf rule.
  - is_signed=0 behaves exactly as unsigned.
- MULT_SIGNED_EN undefined: no is_signed port, unsigned only, and no negate logic is synthesised.

## Test plan
- Unsigned, WIDTH=5, 25*16: out=400 (10'b0110010000), ovf=1, out_valid exactly 5 cycles after accept.
- 31*1: out=31, ovf=0, latency 5. Then 0*20: out=0, ovf=0, latency 1.
- Backpressure, 7*9: hold out_ready=0 for 3 cycles after out_valid. out=63 stays stable, in_ready=0, and a changed in1/in2 during the hold is ignored. Release out_ready: the state goes to IDLE.
- Back-to-back:
  - Sequence 3*3 then 5*6, with in_valid held high and out_ready=1.
  - Second accept happens in the DONE cycle of the first.
  - Results are 9 then 30, with 5 cycles between the two out_valid pulses.
- Reset mid-op: start 31*31, assert reset in the 3rd RUN cycle. Next edge gives IDLE, out=0, out_valid=0. Then 2*3 gives 6 normally.
- MULT_SIGNED_EN, is_signed=1:
  - -3*5: out=10'b1111110001 (-15), ovf=0.
  - -16*-1: out=16, ovf=1.
  - -3*5 with is_signed=0 (29*5): out=145, ovf=1.
